// File: rtl/wb_initiator_pkg.sv
// Shared types for the Wishbone command initiator: bus widths, FSM states
// and the packed command word carried through the command FIFO.
package wb_initiator_pkg;

  localparam int WB_AW = 32;
  localparam int WB_DW = 32;
  localparam int WB_SW = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RSP  = 2'd2
  } state_e;

  // 69-bit command word: {we, sel, adr, dat}
  typedef struct packed {
    logic             we;
    logic [WB_SW-1:0] sel;
    logic [WB_AW-1:0] adr;
    logic [WB_DW-1:0] dat;
  } wb_cmd_t;

  localparam int WB_CMD_W = $bits(wb_cmd_t);

endpackage

// File: rtl/wb_cmd_fifo.sv
// Command FIFO for the Wishbone initiator. Pointers carry one extra wrap
// bit so that full and empty can be told apart when the indices match.
module wb_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 69
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  // A pop frees a slot in the same cycle, so a push alongside a pop is
  // accepted even when full; the occupancy is unchanged in that case.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = mem[rd_ptr[AW-1:0]];

  // Pointer update; the extra MSB toggles on each wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments in clocked blocks, so every flop samples
    // the pre-edge value of every other flop regardless of statement order.
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write.
  // NOTE: the array has no reset; empty/full come from the pointers, so a
  // stale entry is never observed and the RAM stays free of reset fan-out.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/wb_cmd_initiator.sv
// Wishbone classic single-transfer initiator. Commands queue in a small FIFO,
// each becomes one cyc/stb transfer that ends on ack or on a bus timeout, and
// each produces exactly one response on a valid/ready port, in command order.
module wb_cmd_initiator
  import wb_initiator_pkg::*;
#(
  parameter int CMD_DEPTH      = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_ni,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic             cmd_we_i,
  input  logic [WB_AW-1:0] cmd_adr_i,
  input  logic [WB_DW-1:0] cmd_dat_i,
  input  logic [WB_SW-1:0] cmd_sel_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [WB_DW-1:0] rsp_dat_o,
  output logic             rsp_err_o,
  output logic             rsp_we_o,
  output logic             wbm_cyc_o,
  output logic             wbm_stb_o,
  output logic             wbm_we_o,
  output logic [WB_SW-1:0] wbm_sel_o,
  output logic [WB_AW-1:0] wbm_adr_o,
  output logic [WB_DW-1:0] wbm_dat_o,
  input  logic [WB_DW-1:0] wbm_dat_i,
  input  logic             wbm_ack_i,
  output logic             busy_o
);

  localparam int             CW      = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0]  TO_LAST = CW'(TIMEOUT_CYCLES - 1);

  state_e        state;
  logic [CW-1:0] to_cnt;
  logic          cyc;
  wb_cmd_t       cmd_in;
  wb_cmd_t       cmd_head;
  logic          fifo_full;
  logic          fifo_empty;
  logic          push;
  logic          pop;
  logic          rsp_done;

  assign cmd_in = '{we: cmd_we_i, sel: cmd_sel_i, adr: cmd_adr_i, dat: cmd_dat_i};

  // Ready is held low while reset is asserted, not just while full.
  assign cmd_ready_o = wb_rst_ni & ~fifo_full;
  assign push        = cmd_valid_i & cmd_ready_o;
  assign rsp_done    = rsp_valid_o & rsp_ready_i;

  // The head leaves the FIFO whenever the FSM can start a transfer: from IDLE,
  // or straight out of RSP on the edge the pending response is consumed.
  assign pop = ~fifo_empty & ((state == IDLE) | ((state == RSP) & rsp_done));

  assign wbm_cyc_o = cyc;
  assign wbm_stb_o = cyc;
  assign busy_o    = ~fifo_empty | (state != IDLE);

  wb_cmd_fifo #(
    .DEPTH (CMD_DEPTH),
    .WIDTH (WB_CMD_W)
  ) u_fifo (
    .clk       (wb_clk_i),
    .rst_n     (wb_rst_ni),
    .push      (push),
    .push_data (cmd_in),
    .pop       (pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (cmd_head)
  );

  // Transfer FSM: bus request, timeout counting and response capture.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state       <= IDLE;
      to_cnt      <= '0;
      cyc         <= 1'b0;
      wbm_we_o    <= 1'b0;
      wbm_sel_o   <= '0;
      wbm_adr_o   <= '0;
      wbm_dat_o   <= '0;
      rsp_valid_o <= 1'b0;
      rsp_err_o   <= 1'b0;
      rsp_dat_o   <= '0;
      rsp_we_o    <= 1'b0;
    end else begin
      case (state)
        IDLE: ;
        REQ: begin
          // Ack is checked first so that an ack on the final cycle wins.
          if (wbm_ack_i) begin
            cyc         <= 1'b0;
            rsp_valid_o <= 1'b1;
            rsp_err_o   <= 1'b0;
            rsp_dat_o   <= wbm_we_o ? '0 : wbm_dat_i;
            rsp_we_o    <= wbm_we_o;
            state       <= RSP;
          end else if (to_cnt == TO_LAST) begin
            cyc         <= 1'b0;
            rsp_valid_o <= 1'b1;
            rsp_err_o   <= 1'b1;
            rsp_dat_o   <= '0;
            rsp_we_o    <= wbm_we_o;
            state       <= RSP;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        RSP: begin
          if (rsp_done) begin
            rsp_valid_o <= 1'b0;
            rsp_err_o   <= 1'b0;
            rsp_dat_o   <= '0;
            rsp_we_o    <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      // Starting a transfer overrides the IDLE assignment made above when
      // RSP hands over directly to the next queued command.
      if (pop) begin
        state     <= REQ;
        cyc       <= 1'b1;
        to_cnt    <= '0;
        wbm_we_o  <= cmd_head.we;
        wbm_sel_o <= cmd_head.sel;
        wbm_adr_o <= cmd_head.adr;
        wbm_dat_o <= cmd_head.dat;
      end
    end
  end

endmodule

// File: tb/tb_wb_cmd_initiator.sv
// Bench for wb_cmd_initiator: directed commands, a programmable responder,
// and a transaction-level model that predicts bus and response activity.
module tb_wb_cmd_initiator;

  localparam int DEPTH = 4;
  localparam int TO    = 8;
  localparam int NTX   = 32;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid_i;
  logic        cmd_ready_o;
  logic        cmd_we_i;
  logic [31:0] cmd_adr_i;
  logic [31:0] cmd_dat_i;
  logic [3:0]  cmd_sel_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [31:0] rsp_dat_o;
  logic        rsp_err_o;
  logic        rsp_we_o;
  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic        wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic [31:0] wbm_dat_i;
  logic        wbm_ack_i;
  logic        busy_o;

  always #5 clk = ~clk;

  wb_cmd_initiator #(
    .CMD_DEPTH      (DEPTH),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .wb_clk_i    (clk),
    .wb_rst_ni   (rst_n),
    .cmd_valid_i (cmd_valid_i),
    .cmd_ready_o (cmd_ready_o),
    .cmd_we_i    (cmd_we_i),
    .cmd_adr_i   (cmd_adr_i),
    .cmd_dat_i   (cmd_dat_i),
    .cmd_sel_i   (cmd_sel_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_ready_i (rsp_ready_i),
    .rsp_dat_o   (rsp_dat_o),
    .rsp_err_o   (rsp_err_o),
    .rsp_we_o    (rsp_we_o),
    .wbm_cyc_o   (wbm_cyc_o),
    .wbm_stb_o   (wbm_stb_o),
    .wbm_we_o    (wbm_we_o),
    .wbm_sel_o   (wbm_sel_o),
    .wbm_adr_o   (wbm_adr_o),
    .wbm_dat_o   (wbm_dat_o),
    .wbm_dat_i   (wbm_dat_i),
    .wbm_ack_i   (wbm_ack_i),
    .busy_o      (busy_o)
  );

  // One accepted command plus how the responder treats it: ack arrives in
  // bus cycle delay+1 (never, if that exceeds the timeout) with rdata.
  typedef struct {
    logic        we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [31:0] rdata;
    int          delay;
  } tx_t;

  tx_t         txs [NTX];
  int          len_obs [NTX];
  logic [31:0] obs_dat [NTX];
  logic        obs_err [NTX];
  logic        obs_we  [NTX];

  int n_checks = 0;
  int n_errors = 0;

  // Model state: accepted, started and consumed command counts.
  int   n_acc = 0;
  int   issued = 0;
  int   n_cons = 0;
  int   cur = 0;
  int   cyc_cnt = 0;
  bit   in_xfer = 0;
  bit   rsp_pend = 0;
  bit   start_pending = 0;
  bit   exp_cyc;
  bit   mon_en = 0;
  bit   rsp_ready_en = 0;
  bit   spur_en = 0;
  logic        err_e;
  logic [31:0] dat_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Bus cycles a command keeps cyc high: until its ack, capped by the timeout.
  function automatic int exp_len(input int delay);
    return (delay + 1 <= TO) ? delay + 1 : TO;
  endfunction

  // Offer a command until accepted (bounded), then record it in the model.
  task automatic push_cmd(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                          input logic [3:0] sel, input int delay, input logic [31:0] rdata);
    bit ok = 0;
    int tries = 0;
    while (!ok && tries < 200) begin
      @(negedge clk);
      cmd_valid_i = 1'b1;
      cmd_we_i    = we;
      cmd_adr_i   = adr;
      cmd_dat_i   = dat;
      cmd_sel_i   = sel;
      #1 ok = cmd_ready_o;
      @(posedge clk);
      if (ok) begin
        txs[n_acc] = '{we: we, sel: sel, adr: adr, dat: dat, rdata: rdata, delay: delay};
        n_acc++;
      end
      tries++;
    end
    #1 cmd_valid_i = 1'b0;
    check("push_accept", 32'(ok), 32'd1);
  endtask

  // Wait (bounded) until every accepted command has been answered.
  task automatic wait_drain();
    int cycles = 0;
    while ((n_cons != n_acc || in_xfer) && cycles < 300) begin
      @(posedge clk);
      cycles++;
    end
    check("drain", n_cons, n_acc);
  endtask

  // Compare process and responder, both on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (in_xfer) exp_cyc = (cyc_cnt < exp_len(txs[cur].delay));
        else         exp_cyc = start_pending;
        check("cyc", wbm_cyc_o, exp_cyc);
        check("stb", wbm_stb_o, exp_cyc);
        check("busy", busy_o, 32'(n_acc != n_cons));

        if (exp_cyc) begin
          if (!in_xfer) begin
            in_xfer = 1;
            cur     = issued;
            issued++;
            cyc_cnt = 0;
          end
          cyc_cnt++;
          check("wbm_adr", wbm_adr_o, txs[cur].adr);
          check("wbm_dat", wbm_dat_o, txs[cur].dat);
          check("wbm_sel", wbm_sel_o, txs[cur].sel);
          check("wbm_we",  wbm_we_o,  txs[cur].we);
        end else if (in_xfer) begin
          in_xfer      = 0;
          rsp_pend     = 1;
          len_obs[cur] = cyc_cnt;
        end

        check("cmd_ready", cmd_ready_o, 32'((n_acc - issued) < DEPTH));
        check("rsp_valid", rsp_valid_o, rsp_pend);
        if (rsp_pend) begin
          err_e = (txs[n_cons].delay + 1 > TO);
          dat_e = (err_e || txs[n_cons].we) ? 32'h0 : txs[n_cons].rdata;
          check("rsp_err", rsp_err_o, err_e);
          check("rsp_dat", rsp_dat_o, dat_e);
          check("rsp_we",  rsp_we_o,  txs[n_cons].we);
        end

        if (exp_cyc && cyc_cnt == txs[cur].delay + 1) begin
          wbm_ack_i = 1'b1;
          wbm_dat_i = txs[cur].rdata;
        end else if (!exp_cyc && rsp_pend && spur_en) begin
          wbm_ack_i = 1'b1;
          wbm_dat_i = 32'hBADB_AD00;
        end else begin
          wbm_ack_i = 1'b0;
          wbm_dat_i = 32'h0BAD_F00D;
        end

        rsp_ready_i = rsp_ready_en;
        if (rsp_pend && rsp_ready_i) begin
          obs_dat[n_cons] = rsp_dat_o;
          obs_err[n_cons] = rsp_err_o;
          obs_we[n_cons]  = rsp_we_o;
          n_cons++;
          rsp_pend = 0;
        end
        start_pending = (n_acc > issued) && !in_xfer && !rsp_pend;
      end
    end
  end

  // Watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < NTX; i++) begin
      len_obs[i] = -1;
      obs_dat[i] = 32'hFFFF_FFFF;
      obs_err[i] = 1'bx;
      obs_we[i]  = 1'bx;
    end
    rst_n       = 1'b0;
    cmd_valid_i = 1'b0;
    cmd_we_i    = 1'b0;
    cmd_adr_i   = '0;
    cmd_dat_i   = '0;
    cmd_sel_i   = '0;
    rsp_ready_i = 1'b0;
    wbm_ack_i   = 1'b0;
    wbm_dat_i   = '0;

    // Reset values.
    #1;
    check("rst_cyc", wbm_cyc_o, 0);
    check("rst_rsp_valid", rsp_valid_o, 0);
    check("rst_cmd_ready", cmd_ready_o, 0);
    check("rst_busy", busy_o, 0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    #1 check("rel_cmd_ready", cmd_ready_o, 1);
    mon_en       = 1;
    rsp_ready_en = 1;

    // Single write, ack one cycle after stb.
    push_cmd(1'b1, 32'h3000_0004, 32'hDEAD_BEEF, 4'hF, 1, 32'h1111_2222);
    wait_drain();
    // Read, ack after three cycles.
    push_cmd(1'b0, 32'h3000_0008, 32'h0000_0000, 4'hF, 3, 32'h0000_0096);
    wait_drain();
    // Read that never acks: timeout.
    push_cmd(1'b0, 32'h3000_000C, 32'h0000_0000, 4'hF, 1000, 32'h5555_5555);
    wait_drain();
    // Read acked on the timeout cycle: ack wins.
    push_cmd(1'b0, 32'h3000_0010, 32'h0000_0000, 4'h3, 7, 32'hCAFE_F00D);
    wait_drain();

    // Queue fill with responses held back, spurious acks during RSP.
    rsp_ready_en = 0;
    spur_en      = 1;
    push_cmd(1'b1, 32'h3000_0020, 32'h0000_00A1, 4'h1, 0, 32'h7777_0001);
    push_cmd(1'b0, 32'h3000_0024, 32'h0000_0000, 4'hF, 2, 32'h0000_00B2);
    push_cmd(1'b0, 32'h3000_0028, 32'h0000_0000, 4'hC, 1, 32'h0000_00C3);
    push_cmd(1'b1, 32'h3000_002C, 32'h0000_00D4, 4'hF, 0, 32'h7777_0002);
    push_cmd(1'b0, 32'h3000_0030, 32'h0000_0000, 4'hF, 4, 32'h0000_00E5);
    @(negedge clk);
    #1 check("fifo_full_ready", cmd_ready_o, 0);
    fork
      push_cmd(1'b0, 32'h3000_0034, 32'h0000_0000, 4'hF, 0, 32'h0000_00F6);
      begin
        repeat (5) @(posedge clk);
        rsp_ready_en = 1;
      end
    join
    wait_drain();
    spur_en = 0;

    // Reset in the middle of a transfer.
    push_cmd(1'b0, 32'h3000_0040, 32'h0000_0000, 4'hF, 1000, 32'h0000_0099);
    repeat (3) @(posedge clk);
    #2;
    mon_en    = 0;
    rst_n     = 1'b0;
    wbm_ack_i = 1'b0;
    #1;
    check("midreq_rst_cyc", wbm_cyc_o, 0);
    check("midreq_rst_stb", wbm_stb_o, 0);
    check("midreq_rst_rsp_valid", rsp_valid_o, 0);
    check("midreq_rst_cmd_ready", cmd_ready_o, 0);
    in_xfer       = 0;
    rsp_pend      = 0;
    start_pending = 0;
    cyc_cnt       = 0;
    issued        = n_acc;
    n_cons        = n_acc;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    #1;
    check("post_rst_busy", busy_o, 0);
    check("post_rst_cmd_ready", cmd_ready_o, 1);
    mon_en = 1;
    repeat (20) @(posedge clk);

    // Recovery after reset.
    push_cmd(1'b1, 32'h3000_0050, 32'h1234_5678, 4'hF, 2, 32'h7777_0003);
    wait_drain();

    // Hand-computed expectations pinning the model.
    check("t1_len", len_obs[0], 2);
    check("t1_dat", obs_dat[0], 32'h0);
    check("t1_err", obs_err[0], 0);
    check("t1_we",  obs_we[0], 1);
    check("t2_len", len_obs[1], 4);
    check("t2_dat", obs_dat[1], 32'h0000_0096);
    check("t2_err", obs_err[1], 0);
    check("t3_len", len_obs[2], 8);
    check("t3_err", obs_err[2], 1);
    check("t3_dat", obs_dat[2], 32'h0);
    check("t4_len", len_obs[3], 8);
    check("t4_err", obs_err[3], 0);
    check("t4_dat", obs_dat[3], 32'hCAFE_F00D);
    check("q_dat5", obs_dat[5], 32'h0000_00B2);
    check("q_dat7", obs_dat[7], 32'h0);
    check("q_len8", len_obs[8], 5);
    check("q_dat9", obs_dat[9], 32'h0000_00F6);
    check("rec_len", len_obs[11], 3);
    check("rec_we",  obs_we[11], 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
